// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port IDs, command payload.
`include "system_defines.svh"

package mem_arbiter_pkg;

  localparam int unsigned XLEN = `XLEN;
  localparam int unsigned BE_W = `BYTEENABLE_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    READ_WAIT = 2'd2,
    RESPOND   = 2'd3
  } state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_e;

  // Command captured from the winning requester; write=0 means read.
  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] writedata;
    logic [BE_W-1:0] byteenable;
    logic            write;
  } mem_cmd_t;

endpackage

// File: rtl/mod_rr_arbiter2.sv
// Combinational two-way round-robin picker: on a tie the port not granted last wins.
module mod_rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  port_id_e   last_grant,
  output logic [1:0] grant_c,
  output port_id_e   port_id_c
);

  // Pick the winner; grant_c is one-hot, all-zero when nobody requests.
  always_comb begin
    grant_c   = 2'b00;
    port_id_c = PORT0;
    if (req0 && req1) begin
      if (last_grant == PORT1) begin
        grant_c   = 2'b01;
        port_id_c = PORT0;
      end else begin
        grant_c   = 2'b10;
        port_id_c = PORT1;
      end
    end else if (req0) begin
      grant_c   = 2'b01;
      port_id_c = PORT0;
    end else if (req1) begin
      grant_c   = 2'b10;
      port_id_c = PORT1;
    end
  end

endmodule

// File: rtl/system_defines.svh
`ifndef SYSTEM_DEFINES_SVH
`define SYSTEM_DEFINES_SVH

`define XLEN 32
`define BYTEENABLE_WIDTH 4

`endif

// File: rtl/mod_mem_arbiter.sv
// Arbitrates instruction- and data-cache requests onto one memory port,
// one transaction at a time, with round-robin fairness on ties.
module mod_mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic [XLEN-1:0] p0_address_i,
  input  logic [XLEN-1:0] p0_writedata_i,
  input  logic            p0_read_i,
  input  logic            p0_write_i,
  input  logic [BE_W-1:0] p0_byteenable_i,
  output logic [XLEN-1:0] p0_readdata_o,
  output logic            p0_stb_o,

  input  logic [XLEN-1:0] p1_address_i,
  input  logic [XLEN-1:0] p1_writedata_i,
  input  logic            p1_read_i,
  input  logic            p1_write_i,
  input  logic [BE_W-1:0] p1_byteenable_i,
  output logic [XLEN-1:0] p1_readdata_o,
  output logic            p1_stb_o,

  output logic [XLEN-1:0] mem_address_o,
  output logic [XLEN-1:0] mem_writedata_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic [BE_W-1:0] mem_byteenable_o,
  input  logic            mem_waitrequest_i,
  input  logic [XLEN-1:0] mem_readdata_i,
  input  logic            mem_readdatavalid_i
);

  state_e   state;
  port_id_e last_grant;
  port_id_e owner;
  logic     cmd_write;

  logic       req0_c;
  logic       req1_c;
  logic [1:0] grant_c;
  port_id_e   port_id_c;
  mem_cmd_t   sel_cmd_c;

  assign req0_c = p0_read_i | p0_write_i;
  assign req1_c = p1_read_i | p1_write_i;

  mod_rr_arbiter2 u_rr (
    .req0      (req0_c),
    .req1      (req1_c),
    .last_grant(last_grant),
    .grant_c   (grant_c),
    .port_id_c (port_id_c)
  );

  // Mux the winner's command; a simultaneous read+write is taken as a write.
  always_comb begin
    sel_cmd_c = '0;
    if (port_id_c == PORT1) begin
      sel_cmd_c.address    = p1_address_i;
      sel_cmd_c.writedata  = p1_writedata_i;
      sel_cmd_c.byteenable = p1_byteenable_i;
      sel_cmd_c.write      = p1_write_i;
    end else begin
      sel_cmd_c.address    = p0_address_i;
      sel_cmd_c.writedata  = p0_writedata_i;
      sel_cmd_c.byteenable = p0_byteenable_i;
      sel_cmd_c.write      = p0_write_i;
    end
  end

  // Transaction FSM with registered memory command and per-port response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      last_grant       <= PORT1;
      owner            <= PORT0;
      cmd_write        <= 1'b0;
      mem_address_o    <= '0;
      mem_writedata_o  <= '0;
      mem_byteenable_o <= '0;
      mem_read_o       <= 1'b0;
      mem_write_o      <= 1'b0;
      p0_stb_o         <= 1'b0;
      p1_stb_o         <= 1'b0;
      p0_readdata_o    <= '0;
      p1_readdata_o    <= '0;
    end else begin
      p0_stb_o      <= 1'b0;
      p1_stb_o      <= 1'b0;
      p0_readdata_o <= '0;
      p1_readdata_o <= '0;
      case (state)
        IDLE: begin
          if (grant_c != 2'b00) begin
            owner            <= port_id_c;
            last_grant       <= port_id_c;
            cmd_write        <= sel_cmd_c.write;
            mem_address_o    <= sel_cmd_c.address;
            mem_writedata_o  <= sel_cmd_c.writedata;
            mem_byteenable_o <= sel_cmd_c.byteenable;
            mem_write_o      <= sel_cmd_c.write;
            mem_read_o       <= ~sel_cmd_c.write;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_waitrequest_i) begin
            mem_address_o    <= '0;
            mem_writedata_o  <= '0;
            mem_byteenable_o <= '0;
            mem_read_o       <= 1'b0;
            mem_write_o      <= 1'b0;
            if (cmd_write) begin
              state <= RESPOND;
              if (owner == PORT1) p1_stb_o <= 1'b1;
              else                p0_stb_o <= 1'b1;
            end else begin
              state <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_readdatavalid_i) begin
            state <= RESPOND;
            if (owner == PORT1) begin
              p1_stb_o      <= 1'b1;
              p1_readdata_o <= mem_readdata_i;
            end else begin
              p0_stb_o      <= 1'b1;
              p0_readdata_o <= mem_readdata_i;
            end
          end
        end
        RESPOND: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Directed scoreboard bench for mod_mem_arbiter.
module tb_mod_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic            clk_i;
  logic            rst_ni;
  logic [XLEN-1:0] p0_address_i, p0_writedata_i, p0_readdata_o;
  logic            p0_read_i, p0_write_i, p0_stb_o;
  logic [BE_W-1:0] p0_byteenable_i;
  logic [XLEN-1:0] p1_address_i, p1_writedata_i, p1_readdata_o;
  logic            p1_read_i, p1_write_i, p1_stb_o;
  logic [BE_W-1:0] p1_byteenable_i;
  logic [XLEN-1:0] mem_address_o, mem_writedata_o, mem_readdata_i;
  logic            mem_read_o, mem_write_o, mem_waitrequest_i, mem_readdatavalid_i;
  logic [BE_W-1:0] mem_byteenable_o;

  typedef struct {
    logic            port;
    logic [XLEN-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  mod_mem_arbiter dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .p0_address_i       (p0_address_i),
    .p0_writedata_i     (p0_writedata_i),
    .p0_read_i          (p0_read_i),
    .p0_write_i         (p0_write_i),
    .p0_byteenable_i    (p0_byteenable_i),
    .p0_readdata_o      (p0_readdata_o),
    .p0_stb_o           (p0_stb_o),
    .p1_address_i       (p1_address_i),
    .p1_writedata_i     (p1_writedata_i),
    .p1_read_i          (p1_read_i),
    .p1_write_i         (p1_write_i),
    .p1_byteenable_i    (p1_byteenable_i),
    .p1_readdata_o      (p1_readdata_o),
    .p1_stb_o           (p1_stb_o),
    .mem_address_o      (mem_address_o),
    .mem_writedata_o    (mem_writedata_o),
    .mem_read_o         (mem_read_o),
    .mem_write_o        (mem_write_o),
    .mem_byteenable_o   (mem_byteenable_o),
    .mem_waitrequest_i  (mem_waitrequest_i),
    .mem_readdata_i     (mem_readdata_i),
    .mem_readdatavalid_i(mem_readdatavalid_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic push(input logic port, input logic [XLEN-1:0] data);
    resp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic no_stb(input string tag);
    chk({tag, "_p0_stb"}, 64'(p0_stb_o), 64'd0);
    chk({tag, "_p1_stb"}, 64'(p1_stb_o), 64'd0);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_mem_rd"},   64'(mem_read_o), 64'd0);
    chk({tag, "_mem_wr"},   64'(mem_write_o), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_address_o), 64'd0);
    chk({tag, "_mem_wd"},   64'(mem_writedata_o), 64'd0);
    chk({tag, "_mem_be"},   64'(mem_byteenable_o), 64'd0);
    chk({tag, "_p0_rd"},    64'(p0_readdata_o), 64'd0);
    chk({tag, "_p1_rd"},    64'(p1_readdata_o), 64'd0);
    no_stb(tag);
  endtask

  // Compare the current strobe against the oldest scoreboard entry.
  task automatic expect_resp(input string tag);
    resp_t e;
    chk({tag, "_stb_any"}, 64'(p0_stb_o | p1_stb_o), 64'd1);
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_p0_stb"}, 64'(p0_stb_o), 64'(e.port == 1'b0));
      chk({tag, "_p1_stb"}, 64'(p1_stb_o), 64'(e.port == 1'b1));
      chk({tag, "_p0_rdata"}, 64'(p0_readdata_o), (e.port == 1'b0) ? 64'(e.data) : 64'd0);
      chk({tag, "_p1_rdata"}, 64'(p1_readdata_o), (e.port == 1'b1) ? 64'(e.data) : 64'd0);
    end
  endtask

  // Bounded wait for a command to appear on the memory side.
  task automatic wait_cmd(input string tag);
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_read_o || mem_write_o) break;
    end
    chk({tag, "_cmd_seen"}, 64'(mem_read_o | mem_write_o), 64'd1);
  endtask

  initial begin
    rst_ni = 1'b0;
    p0_address_i = '0; p0_writedata_i = '0; p0_read_i = 1'b0; p0_write_i = 1'b0; p0_byteenable_i = '0;
    p1_address_i = '0; p1_writedata_i = '0; p1_read_i = 1'b0; p1_write_i = 1'b0; p1_byteenable_i = '0;
    mem_waitrequest_i = 1'b0; mem_readdata_i = '0; mem_readdatavalid_i = 1'b0;

    step();
    outputs_zero("reset");
    step();
    rst_ni = 1'b1;
    step();

    // p0 read, data one cycle after acceptance: stb three cycles after request
    p0_address_i = 32'h0000_0100; p0_read_i = 1'b1;
    push(1'b0, 32'hDEAD_BEEF);
    step();
    chk("r025_issue_rd", 64'(mem_read_o), 64'd1);
    chk("r025_issue_wr", 64'(mem_write_o), 64'd0);
    chk("r025_issue_addr", 64'(mem_address_o), 64'h100);
    no_stb("r025_c1");
    step();
    chk("r025_wait_rd", 64'(mem_read_o), 64'd0);
    no_stb("r025_c2");
    mem_readdatavalid_i = 1'b1; mem_readdata_i = 32'hDEAD_BEEF;
    step();
    expect_resp("r025");
    mem_readdatavalid_i = 1'b0; mem_readdata_i = '0; p0_read_i = 1'b0;
    step();
    no_stb("r025_after");

    // p1 write stalled three cycles; stray readdatavalid during ISSUE ignored
    p1_address_i = 32'h0000_0200; p1_writedata_i = 32'hCAFE_F00D;
    p1_byteenable_i = 4'b0011; p1_write_i = 1'b1; mem_waitrequest_i = 1'b1;
    push(1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("r026_stall%0d_wr", i), 64'(mem_write_o), 64'd1);
      chk($sformatf("r026_stall%0d_rd", i), 64'(mem_read_o), 64'd0);
      chk($sformatf("r026_stall%0d_addr", i), 64'(mem_address_o), 64'h200);
      chk($sformatf("r026_stall%0d_wd", i), 64'(mem_writedata_o), 64'hCAFE_F00D);
      chk($sformatf("r026_stall%0d_be", i), 64'(mem_byteenable_o), 64'h3);
      no_stb($sformatf("r026_stall%0d", i));
      if (i == 0) begin mem_readdatavalid_i = 1'b1; mem_readdata_i = 32'hBAD0_BAD0; end
      if (i == 1) begin mem_readdatavalid_i = 1'b0; mem_readdata_i = '0; end
      if (i == 3) mem_waitrequest_i = 1'b0;
    end
    step();
    expect_resp("r026");
    p1_write_i = 1'b0;
    step();
    no_stb("r026_after");

    // both ports hold reads: grants alternate starting with p0
    p0_address_i = 32'h0000_0300; p1_address_i = 32'h0000_0400;
    p0_read_i = 1'b1; p1_read_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(1'(k % 2), 32'h1000 + 32'(k));
      wait_cmd($sformatf("r027_t%0d", k));
      chk($sformatf("r027_t%0d_addr", k), 64'(mem_address_o), (k % 2 == 1) ? 64'h400 : 64'h300);
      chk($sformatf("r027_t%0d_rd", k), 64'(mem_read_o), 64'd1);
      step();
      mem_readdatavalid_i = 1'b1; mem_readdata_i = 32'h1000 + 32'(k);
      step();
      if (k == 3) begin p0_read_i = 1'b0; p1_read_i = 1'b0; end
      expect_resp($sformatf("r027_t%0d", k));
      mem_readdatavalid_i = 1'b0; mem_readdata_i = '0;
    end
    step();
    no_stb("r027_after");

    // read+write together on p0 is issued as a write
    p0_address_i = 32'h0000_0700; p0_writedata_i = 32'h1234_5678; p0_byteenable_i = 4'hF;
    p0_read_i = 1'b1; p0_write_i = 1'b1;
    push(1'b0, 32'h0);
    step();
    chk("r030_wr", 64'(mem_write_o), 64'd1);
    chk("r030_rd", 64'(mem_read_o), 64'd0);
    chk("r030_wd", 64'(mem_writedata_o), 64'h1234_5678);
    step();
    expect_resp("r030");
    p0_read_i = 1'b0; p0_write_i = 1'b0;
    step();
    no_stb("r030_after");

    // p1 read dropped during READ_WAIT still completes exactly once
    p1_address_i = 32'h0000_0500; p1_read_i = 1'b1;
    push(1'b1, 32'hA5A5_0028);
    step();
    chk("r028_issue_rd", 64'(mem_read_o), 64'd1);
    chk("r028_issue_addr", 64'(mem_address_o), 64'h500);
    step();
    p1_read_i = 1'b0;
    no_stb("r028_w0");
    step();
    no_stb("r028_w1");
    step();
    no_stb("r028_w2");
    mem_readdatavalid_i = 1'b1; mem_readdata_i = 32'hA5A5_0028;
    step();
    expect_resp("r028");
    mem_readdatavalid_i = 1'b0; mem_readdata_i = '0;
    step();
    no_stb("r028_once0");
    step();
    no_stb("r028_once1");

    // reset during READ_WAIT, stray readdatavalid afterwards ignored
    p0_address_i = 32'h0000_0600; p0_read_i = 1'b1;
    step();
    chk("r029_issue_rd", 64'(mem_read_o), 64'd1);
    step();
    p0_read_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 outputs_zero("r029_rst");
    step();
    step();
    rst_ni = 1'b1;
    step();
    mem_readdatavalid_i = 1'b1; mem_readdata_i = 32'h0000_5747;
    step();
    mem_readdatavalid_i = 1'b0; mem_readdata_i = '0;
    outputs_zero("r029_stray0");
    step();
    no_stb("r029_stray1");
    step();
    no_stb("r029_stray2");
    p1_address_i = 32'h0000_0900; p1_write_i = 1'b1; p1_writedata_i = 32'h0;
    push(1'b1, 32'h0);
    step();
    chk("r029_idle_wr", 64'(mem_write_o), 64'd1);
    chk("r029_idle_addr", 64'(mem_address_o), 64'h900);
    step();
    expect_resp("r029_idle");
    p1_write_i = 1'b0;
    step();

    // reset while a command is on the bus clears it without a clock edge
    p1_address_i = 32'h0000_0800; p1_writedata_i = 32'h0BAD_0800; p1_write_i = 1'b1;
    mem_waitrequest_i = 1'b1;
    step();
    chk("rst_issue_wr", 64'(mem_write_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1 outputs_zero("rst_issue");
    p1_write_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1; mem_waitrequest_i = 1'b0;
    step();
    no_stb("rst_issue_after0");
    step();
    no_stb("rst_issue_after1");

    // after reset p0 wins the first tie, then p1 gets its turn
    p0_address_i = 32'h0000_0A00; p0_write_i = 1'b1;
    p1_address_i = 32'h0000_0B00; p1_write_i = 1'b1;
    push(1'b0, 32'h0);
    step();
    chk("tie_first_addr", 64'(mem_address_o), 64'hA00);
    step();
    expect_resp("tie_first");
    p0_write_i = 1'b0;
    push(1'b1, 32'h0);
    wait_cmd("tie_second");
    chk("tie_second_addr", 64'(mem_address_o), 64'hB00);
    step();
    expect_resp("tie_second");
    p1_write_i = 1'b0;
    step();
    no_stb("tie_after");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_mem_arbiter.md
MOD_MEM_ARBITER -- requirements
Module: mod_mem_arbiter

Interface
REQ-001 SHALL use `XLEN (32) for address and data width and `BYTEENABLE_WIDTH (4) for byte enables; no other parameters.
REQ-002 SHALL have exactly one clock and an asynchronous, active-low reset: clk_i input 1 (rising edge); rst_ni input 1 (async assert, active-low).
REQ-003 SHALL provide two requester ports, p0 (instruction cache) and p1 (data cache), each carrying the signals in REQ-004 to REQ-006.
REQ-004 Port inputs: pN_address_i (`XLEN), pN_writedata_i (`XLEN), pN_read_i (1), pN_write_i (1) and pN_byteenable_i (`BYTEENABLE_WIDTH); all are level-held requests from the cache.
REQ-005 pN_readdata_o output `XLEN: read result, valid while pN_stb_o is high.
REQ-006 pN_stb_o output 1: single-cycle completion pulse; drives the cache's memory_operation_stb_i.
REQ-007 Memory-side outputs: mem_address_o (`XLEN), mem_writedata_o (`XLEN), mem_read_o (1), mem_write_o (1), mem_byteenable_o (`BYTEENABLE_WIDTH).
REQ-008 Memory-side inputs: mem_waitrequest_i (1, command stall), mem_readdata_i (`XLEN) and mem_readdatavalid_i (1).

Function
REQ-009 States: IDLE, ISSUE, READ_WAIT, RESPOND.
REQ-010 IDLE:
- A port is requesting when read or write is high.
- If any port is requesting, the arbiter latches the winner's address, writedata, byteenable, operation and port ID, then moves to ISSUE on the next edge.
REQ-011 Winner selection is round-robin:
- If both ports request, the port not granted last wins.
- last_grant updates at each IDLE->ISSUE transition.
REQ-012 A request with both read and write high SHALL be treated as a write.
REQ-013 ISSUE drives the mem_* outputs from the latched registers only. The command is accepted on a cycle where mem_waitrequest_i=0. On acceptance: write -> RESPOND, read -> READ_WAIT.
REQ-014 READ_WAIT: mem_* command outputs are deasserted. On mem_readdatavalid_i=1, the arbiter captures mem_readdata_i and moves to RESPOND.
REQ-015 RESPOND (one cycle):
- The granted pN_stb_o is 1 for that cycle.
- pN_readdata_o holds the captured data for reads and 0 for writes.
- The other port's stb and readdata are 0.
- Next state is IDLE.
REQ-016 Minimum latency from request seen in IDLE to stb: write 2 cycles with no wait; read 3 cycles when readdatavalid comes in the cycle after acceptance.
REQ-017 Once latched, a transaction SHALL complete and pulse stb even if the requester drops its request mid-transaction (cache abort path).
REQ-018 In the cycle after RESPOND, IDLE SHALL resample requests. A request that is still held is treated as a new transaction; the cache drops its request at stb, so this is legal.
REQ-019 mem_readdatavalid_i outside READ_WAIT SHALL be ignored.
REQ-020 Only one memory transaction SHALL be outstanding at a time; no pipelining.

Reset
REQ-021 Reset assertion takes effect immediately, without waiting for a clock edge. On reset:
- state=IDLE, last_grant=p1 (so p0 wins the first tie).
- All mem_* outputs, pN_stb_o and pN_readdata_o are 0.
REQ-022 Reset mid-transaction SHALL abandon it with no stb. A mem_readdatavalid_i arriving after release SHALL be ignored.

Structure
REQ-023 The state enum and port-ID type SHALL live in a shared package, mem_arbiter_pkg; `XLEN and `BYTEENABLE_WIDTH come from system_defines.svh.
REQ-024 One sub-module is natural: mod_rr_arbiter2, a combinational two-way round-robin picker. Its inputs are two request bits and last_grant; its outputs are grant and port ID.

Verification
REQ-025 p0 read of 0x0000_0100 with no waitrequest and readdatavalid one cycle after acceptance (data 0xDEADBEEF) -> p0_stb_o pulses 3 cycles after the request, with p0_readdata_o=0xDEADBEEF; p1_stb_o stays 0.
REQ-026 p1 write of 0xCAFEF00D to 0x0000_0200 with byteenable 4'b0011 and waitrequest high for 3 cycles -> the mem_* command is stable during all 3 stalled cycles; p1_stb_o pulses the cycle after acceptance.
REQ-027 p0 and p1 read simultaneously and keep requesting -> grants alternate p0, p1, p0, p1, and each stb goes only to its own port.
REQ-028 p1 read issued, then p1_read_i dropped during READ_WAIT -> the arbiter still waits for readdatavalid and pulses p1_stb_o exactly once.
REQ-029 rst_ni asserted during READ_WAIT, then released, then a stray mem_readdatavalid_i arrives -> all outputs go to 0 immediately on assertion, no stb follows, and the state is IDLE.
REQ-030 Request with read=1 and write=1 on p0 -> mem_write_o=1 and mem_read_o=0 issued.
